multi_bullet_draw: RTL and testbench
====================================

Name: multi_bullet_draw

Overview:
Pipelined sprite renderer for up to NUM_BULLETS simultaneous bullets sharing one synchronous sprite ROM. Sits in the pixel pipeline beside the other *_draw blocks. Produces a 12-bit RGB (or MASK) per pixel, plus a hit flag and the index of the winning bullet for the compositor and collision logic. Bullet positions and enables are frame-latched, so game logic may update them at any time without tearing.

Parameters:
NUM_BULLETS, 4, number of bullet channels (1..16)
BULLET_W, 8, sprite width in pixels
BULLET_H, 8, sprite height in pixels
ADDR_W, 6, sprite ROM address width; must satisfy 2^ADDR_W >= BULLET_W*BULLET_H
IDX_W, $clog2(NUM_BULLETS) (min 1), width of bullet index

Ports:
pixclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank; latches shadow registers
pix_valid  in  1  draw_x/draw_y are in the visible area this cycle
draw_x  in  11  current pixel x
draw_y  in  10  current pixel y
bullet_active  in  NUM_BULLETS  per-bullet enable
bullet_pos_x  in  11*NUM_BULLETS  packed x positions, bullet i at [11i+10:11i]
bullet_pos_y  in  10*NUM_BULLETS  packed y positions
bullet_rgb  out  12  pixel colour or `MASK
bullet_hit  out  1  opaque bullet pixel output this cycle
bullet_idx  out  IDX_W  index of the drawn bullet; 0 when bullet_hit=0

Behaviour:
- Reset (async, rst_n=0): bullet_rgb=`MASK, bullet_hit=0, bullet_idx=0, all pipeline valid bits 0, shadow active mask 0, shadow positions 0.
- Shadow registers: on a pixclk edge with frame_start=1, copy bullet_active, bullet_pos_x and bullet_pos_y into the shadow set. All hit tests use only the shadow set. A frame_start in the same cycle as pix_valid is still honoured.
- Hit test for bullet i: active_s[i], pos_x_s <= draw_x < pos_x_s+BULLET_W, and pos_y_s <= draw_y < pos_y_s+BULLET_H. The range is half-open.
- Compute sums at 12/11 bits so a position near 2047/1023 does not wrap. Pixels beyond the screen edge are never drawn.
- Priority: the lowest index wins when bullets overlap.
- Pipeline, fixed latency 3 cycles from draw_x/draw_y/pix_valid to the outputs:
  - S1: hit test, priority encode, register winner index, hit, and local offsets (dx=draw_x-pos_x, dy=draw_y-pos_y, truncated to $clog2 widths).
  - S2: ROM address = dy*BULLET_W+dx, registered and presented to the ROM.
  - S3: ROM data is valid. Output stage registers rgb/hit/idx.
  - Upstream compensates the 3-cycle latency. This block performs no coordinate pre-offset.
- Transparency: if the ROM word equals `MASK, output bullet_rgb=`MASK, bullet_hit=0, bullet_idx=0. The pixel is transparent and lower-priority bullets are not re-examined.
- pix_valid=0 or no hit: outputs `MASK/0/0 three cycles later.
- The ROM address is held (not toggled) when no hit occurs, to save power.
- rst_n deasserted mid-line: the pipeline restarts empty. Outputs stay `MASK until the first valid hit propagates through 3 stages.
- Back-to-back hits on every cycle are supported at full throughput.

Decomposition:
- constants.v holds `MASK, `BULLET_WIDTH and `BULLET_HEIGHT; these feed the BULLET_W/BULLET_H defaults at instantiation.
- Priority encoder: a function inside the module.
- One sub-module: bullet_sprite_rom (clka, addra[ADDR_W-1:0], douta[11:0], 1-cycle synchronous read). It is a simulation model for the bench and the IP ROM in synthesis.

Test Plan:
- Reset: hold rst_n=0 while driving pixels -> bullet_rgb=`MASK, bullet_hit=0, bullet_idx=0. After release, first 3 outputs are `MASK.
- Single bullet: pos (100,50), active, frame_start, then scan line y=50, x=98..110 -> hit exactly for x=100..107, appearing 3 cycles later. Address row 0, rgb equals ROM[dx]. x=108 not drawn.
- Overlap: bullets 0 at (200,60) and 2 at (204,60) -> for x=204..207, bullet_idx=0; for x=208..211, bullet_idx=2.
- Tear-free update: change pos_x of bullet 1 mid-frame without frame_start -> output unchanged until the next frame_start pulse. Then the new position is drawn.
- Transparency and edge: ROM word `MASK at offset (3,0) -> bullet_hit=0 at that pixel. Bullet at x=2044 -> hits only x=2044..2047, no wrap to x=0..3.
- Async reset mid-line: assert rst_n low between pixclk edges during a hit run -> outputs go `MASK immediately, and the shadow enable mask is cleared.

Source files
------------

// File: rtl/multi_bullet_draw_pkg.sv
// Shared constants for the bullet renderer: transparent colour key, default
// sprite geometry and the sprite image used by the ROM simulation model.
package multi_bullet_draw_pkg;

  localparam logic [11:0] MASK          = 12'hF0F;
  localparam int          BULLET_WIDTH  = 8;
  localparam int          BULLET_HEIGHT = 8;

  // Sprite image: two transparent texels (row 0 col 3, row 7 col 4), the rest a colour ramp.
  function automatic logic [11:0] sprite_word(input int unsigned addr);
    if (addr == 3 || addr == 60) return MASK;
    return 12'(32'd256 + addr * 32'd37);
  endfunction

endpackage

// File: rtl/bullet_sprite_rom.sv
// Bullet sprite ROM, one-cycle synchronous read. Stands in for the IP ROM.
module bullet_sprite_rom
  import multi_bullet_draw_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clka,
  input  logic [ADDR_W-1:0] addra,
  output logic [11:0]       douta
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [11:0] rom_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_mem[gi] = sprite_word(gi);
  end

  always_ff @(posedge clka) begin
    douta <= rom_mem[addra];
  end

endmodule

// File: rtl/multi_bullet_draw.sv
// Multi-bullet sprite renderer: frame-latched bullet set, lowest-index priority,
// 3-cycle pipeline (hit test -> ROM read -> output register).
module multi_bullet_draw
  import multi_bullet_draw_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int BULLET_W    = BULLET_WIDTH,
  parameter int BULLET_H    = BULLET_HEIGHT,
  parameter int ADDR_W      = 6,
  parameter int IDX_W       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
  input  logic                     pixclk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [10:0]              draw_x,
  input  logic [9:0]               draw_y,
  input  logic [NUM_BULLETS-1:0]   bullet_active,
  input  logic [11*NUM_BULLETS-1:0] bullet_pos_x,
  input  logic [10*NUM_BULLETS-1:0] bullet_pos_y,
  output logic [11:0]              bullet_rgb,
  output logic                     bullet_hit,
  output logic [IDX_W-1:0]         bullet_idx
);

  localparam int DX_W = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
  localparam int DY_W = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;

  function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_BULLETS-1:0] req);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic [NUM_BULLETS-1:0]    active_s_reg;
  logic [11*NUM_BULLETS-1:0] pos_x_s_reg;
  logic [10*NUM_BULLETS-1:0] pos_y_s_reg;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      active_s_reg <= '0;
      pos_x_s_reg  <= '0;
      pos_y_s_reg  <= '0;
    end else if (frame_start) begin
      active_s_reg <= bullet_active;
      pos_x_s_reg  <= bullet_pos_x;
      pos_y_s_reg  <= bullet_pos_y;
    end
  end

  logic [NUM_BULLETS-1:0] hit_vec;
  logic [DX_W-1:0]        dx_arr [NUM_BULLETS];
  logic [DY_W-1:0]        dy_arr [NUM_BULLETS];

  // Comparisons are one bit wider than the coordinates so pos+size never wraps.
  for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_hit
    logic [11:0] px;
    logic [10:0] py;
    assign px = {1'b0, pos_x_s_reg[11*gi +: 11]};
    assign py = {1'b0, pos_y_s_reg[10*gi +: 10]};
    assign hit_vec[gi] = active_s_reg[gi]
                      && ({1'b0, draw_x} >= px) && ({1'b0, draw_x} < px + 12'(BULLET_W))
                      && ({1'b0, draw_y} >= py) && ({1'b0, draw_y} < py + 11'(BULLET_H));
    assign dx_arr[gi] = DX_W'({1'b0, draw_x} - px);
    assign dy_arr[gi] = DY_W'({1'b0, draw_y} - py);
  end

  logic [IDX_W-1:0] win_idx;
  assign win_idx = prio_enc(hit_vec);

  logic             s1_hit_reg;
  logic [IDX_W-1:0] s1_idx_reg;
  logic [DX_W-1:0]  s1_dx_reg;
  logic [DY_W-1:0]  s1_dy_reg;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit_reg <= 1'b0;
      s1_idx_reg <= '0;
      s1_dx_reg  <= '0;
      s1_dy_reg  <= '0;
    end else begin
      s1_hit_reg <= pix_valid && (|hit_vec);
      s1_idx_reg <= win_idx;
      s1_dx_reg  <= dx_arr[win_idx];
      s1_dy_reg  <= dy_arr[win_idx];
    end
  end

  // Address lines only move on a hit; otherwise the last address is re-presented.
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic              s2_hit_reg;
  logic [IDX_W-1:0]  s2_idx_reg;
  logic [11:0]       rom_data;

  assign rom_addr = s1_hit_reg ? ADDR_W'(int'(s1_dy_reg) * BULLET_W + int'(s1_dx_reg))
                               : rom_addr_reg;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_reg <= '0;
      s2_hit_reg   <= 1'b0;
      s2_idx_reg   <= '0;
    end else begin
      rom_addr_reg <= rom_addr;
      s2_hit_reg   <= s1_hit_reg;
      s2_idx_reg   <= s1_idx_reg;
    end
  end

  bullet_sprite_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clka  (pixclk),
    .addra (rom_addr),
    .douta (rom_data)
  );

  // A transparent texel hides the pixel outright; lower-priority bullets are not consulted.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      bullet_rgb <= MASK;
      bullet_hit <= 1'b0;
      bullet_idx <= '0;
    end else if (s2_hit_reg && (rom_data != MASK)) begin
      bullet_rgb <= rom_data;
      bullet_hit <= 1'b1;
      bullet_idx <= s2_idx_reg;
    end else begin
      bullet_rgb <= MASK;
      bullet_hit <= 1'b0;
      bullet_idx <= '0;
    end
  end

endmodule

// File: tb/tb_multi_bullet_draw.sv
// Self-checking bench for multi_bullet_draw: directed vector table, hand-written
// corner sequences, and randomized pixels against a frame-latched reference model.
module tb_multi_bullet_draw;

  localparam int          NB      = 4;
  localparam logic [11:0] TB_MASK = 12'hF0F;

  logic              pixclk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              pix_valid;
  logic [10:0]       draw_x;
  logic [9:0]        draw_y;
  logic [NB-1:0]     bullet_active;
  logic [11*NB-1:0]  bullet_pos_x;
  logic [10*NB-1:0]  bullet_pos_y;
  logic [11:0]       bullet_rgb;
  logic              bullet_hit;
  logic [1:0]        bullet_idx;

  always #5 pixclk = ~pixclk;

  multi_bullet_draw #(
    .NUM_BULLETS (NB)
  ) dut (
    .pixclk        (pixclk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .draw_x        (draw_x),
    .draw_y        (draw_y),
    .bullet_active (bullet_active),
    .bullet_pos_x  (bullet_pos_x),
    .bullet_pos_y  (bullet_pos_y),
    .bullet_rgb    (bullet_rgb),
    .bullet_hit    (bullet_hit),
    .bullet_idx    (bullet_idx)
  );

  typedef struct {
    string       tag;
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        hit;
    int          idx;
  } exp_t;

  typedef struct {
    logic pv;
    int   x;
    int   y;
    logic hit;
    int   idx;
    int   addr;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   b_act[NB], b_x[NB], b_y[NB];   // values game logic currently drives
  int   s_act[NB], s_x[NB], s_y[NB];   // what the block should have latched
  int   checks = 0;
  int   errors = 0;

  // Expected sprite image: 8x8, transparent at (3,0) and (4,7).
  function automatic logic [11:0] sprite(int a);
    if (a == 3 || a == 60) return TB_MASK;
    return 12'(256 + 37 * a);
  endfunction

  function automatic exp_t ex(string tag, int x, int y, logic hit, int idx, int addr);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y;
    e.hit = hit;
    e.idx = hit ? idx : 0;
    e.rgb = hit ? sprite(addr) : TB_MASK;
    return e;
  endfunction

  function automatic vec_t v(logic pv, int x, int y, logic hit, int idx, int addr);
    vec_t r;
    r.pv = pv; r.x = x; r.y = y; r.hit = hit; r.idx = idx; r.addr = addr;
    return r;
  endfunction

  // Reference: first (lowest) bullet whose box contains the pixel decides the pixel.
  function automatic exp_t model(string tag, logic pv, int x, int y);
    exp_t        e;
    logic [11:0] w;
    e = ex(tag, x, y, 1'b0, 0, 0);
    if (pv) begin
      for (int i = 0; i < NB; i++) begin
        if (s_act[i] != 0 && x >= s_x[i] && x < s_x[i] + 8 && y >= s_y[i] && y < s_y[i] + 8) begin
          w = sprite((y - s_y[i]) * 8 + (x - s_x[i]));
          if (w != TB_MASK) begin
            e.rgb = w; e.hit = 1'b1; e.idx = i;
          end
          return e;
        end
      end
    end
    return e;
  endfunction

  task automatic check_out(exp_t e);
    checks++;
    if (bullet_rgb !== e.rgb || bullet_hit !== e.hit || bullet_idx !== 2'(e.idx)) begin
      errors++;
      $display("FAIL %s x=%0d y=%0d: got rgb=%h hit=%b idx=%0d, want rgb=%h hit=%b idx=%0d",
               e.tag, e.x, e.y, bullet_rgb, bullet_hit, bullet_idx, e.rgb, e.hit, e.idx);
    end else begin
      $display("%s x=%0d y=%0d rgb=%h hit=%b idx=%0d ok",
               e.tag, e.x, e.y, bullet_rgb, bullet_hit, bullet_idx);
    end
  endtask

  task automatic apply_bullets();
    for (int i = 0; i < NB; i++) begin
      bullet_active[i]         = (b_act[i] != 0);
      bullet_pos_x[11*i +: 11] = 11'(b_x[i]);
      bullet_pos_y[10*i +: 10] = 10'(b_y[i]);
    end
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < NB; i++) begin
      s_act[i] = 0; s_x[i] = 0; s_y[i] = 0;
    end
  endtask

  task automatic prime_queue(string tag);
    exp_q.delete();
    exp_q.push_back(ex(tag, 0, 0, 1'b0, 0, 0));
    exp_q.push_back(ex(tag, 0, 0, 1'b0, 0, 0));
  endtask

  // One pixel clock: drive, clock, then compare against the pixel from 3 cycles back.
  task automatic step(logic fs, logic pv, int x, int y, exp_t e);
    apply_bullets();
    frame_start = fs;
    pix_valid   = pv;
    draw_x      = 11'(x);
    draw_y      = 10'(y);
    exp_q.push_back(e);
    if (fs) begin
      s_act = b_act; s_x = b_x; s_y = b_y;
    end
    @(posedge pixclk);
    #1;
    check_out(exp_q.pop_front());
  endtask

  task automatic step_model(string tag, logic fs, logic pv, int x, int y);
    step(fs, pv, x, y, model(tag, pv, x, y));
  endtask

  function automatic int rand_coord(int hi, int lo_span, int hi_span);
    if ($urandom_range(0, 3) == 0) return hi - int'($urandom_range(0, hi_span));
    return int'($urandom_range(0, lo_span));
  endfunction

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; draw_x = '0; draw_y = '0;
    for (int i = 0; i < NB; i++) begin
      b_act[i] = 0; b_x[i] = 0; b_y[i] = 0;
    end
    clear_shadow();
    b_act[1] = 1; b_x[1] = 100; b_y[1] = 50;
    apply_bullets();

    // Reset held while pixels and frame_start are driven.
    for (int k = 0; k < 4; k++) begin
      frame_start = 1'b1; pix_valid = 1'b1; draw_x = 11'(100 + k); draw_y = 10'd50;
      @(posedge pixclk);
      #1;
      check_out(ex("reset_hold", 100 + k, 50, 1'b0, 0, 0));
    end
    frame_start = 1'b0;
    rst_n = 1'b1;
    prime_queue("post_reset");
    for (int k = 0; k < 3; k++) step_model("post_reset", 1'b0, 1'b1, 100 + k, 50);

    // Directed scene latched by one frame_start.
    b_act = '{1, 1, 1, 1};
    b_x   = '{200, 100, 204, 2044};
    b_y   = '{60, 50, 60, 100};
    step_model("latch", 1'b1, 1'b0, 0, 0);

    tbl.push_back(v(1, 98, 50, 0, 0, 0));    tbl.push_back(v(1, 99, 50, 0, 0, 0));
    tbl.push_back(v(1, 100, 50, 1, 1, 0));   tbl.push_back(v(1, 101, 50, 1, 1, 1));
    tbl.push_back(v(1, 102, 50, 1, 1, 2));   tbl.push_back(v(1, 103, 50, 0, 0, 0));
    tbl.push_back(v(1, 104, 50, 1, 1, 4));   tbl.push_back(v(1, 105, 50, 1, 1, 5));
    tbl.push_back(v(1, 106, 50, 1, 1, 6));   tbl.push_back(v(1, 107, 50, 1, 1, 7));
    tbl.push_back(v(1, 108, 50, 0, 0, 0));   tbl.push_back(v(1, 109, 50, 0, 0, 0));
    tbl.push_back(v(1, 110, 50, 0, 0, 0));   tbl.push_back(v(0, 101, 50, 0, 0, 0));
    tbl.push_back(v(1, 101, 57, 1, 1, 57));  tbl.push_back(v(1, 101, 58, 0, 0, 0));
    tbl.push_back(v(1, 203, 60, 0, 0, 0));   tbl.push_back(v(1, 204, 60, 1, 0, 4));
    tbl.push_back(v(1, 207, 60, 1, 0, 7));   tbl.push_back(v(1, 208, 60, 1, 2, 4));
    tbl.push_back(v(1, 211, 60, 1, 2, 7));   tbl.push_back(v(1, 212, 60, 0, 0, 0));
    tbl.push_back(v(1, 204, 67, 0, 0, 0));   tbl.push_back(v(1, 205, 67, 1, 0, 61));
    tbl.push_back(v(1, 2043, 101, 0, 0, 0)); tbl.push_back(v(1, 2044, 101, 1, 3, 8));
    tbl.push_back(v(1, 2046, 101, 1, 3, 10)); tbl.push_back(v(1, 2047, 101, 1, 3, 11));
    tbl.push_back(v(1, 0, 101, 0, 0, 0));    tbl.push_back(v(1, 3, 101, 0, 0, 0));
    tbl.push_back(v(1, 2044, 108, 0, 0, 0));
    for (int k = 0; k < tbl.size(); k++) begin
      step(1'b0, tbl[k].pv, tbl[k].x, tbl[k].y,
           ex("table", tbl[k].x, tbl[k].y, tbl[k].hit, tbl[k].idx, tbl[k].addr));
    end

    // Tear-free: a mid-frame move is invisible until the next frame_start.
    b_x[1] = 300;
    step(1'b0, 1'b1, 100, 50, ex("tear_old", 100, 50, 1'b1, 1, 0));
    step(1'b0, 1'b1, 101, 50, ex("tear_old", 101, 50, 1'b1, 1, 1));
    step(1'b0, 1'b1, 300, 50, ex("tear_old", 300, 50, 1'b0, 0, 0));
    step(1'b1, 1'b1, 300, 50, ex("tear_fs", 300, 50, 1'b0, 0, 0));
    step(1'b0, 1'b1, 300, 50, ex("tear_new", 300, 50, 1'b1, 1, 0));
    step(1'b0, 1'b1, 301, 50, ex("tear_new", 301, 50, 1'b1, 1, 1));
    step(1'b0, 1'b1, 100, 50, ex("tear_new", 100, 50, 1'b0, 0, 0));
    step(1'b0, 1'b1, 302, 50, ex("tear_new", 302, 50, 1'b1, 1, 2));

    // Asynchronous reset between edges in the middle of a hit run.
    for (int k = 0; k < 3; k++) step_model("run", 1'b0, 1'b1, 304 + k, 50);
    #2;
    rst_n = 1'b0;
    #1;
    check_out(ex("async_reset", 306, 50, 1'b0, 0, 0));
    @(posedge pixclk);
    #1;
    check_out(ex("async_reset_hold", 306, 50, 1'b0, 0, 0));
    rst_n = 1'b1;
    clear_shadow();
    prime_queue("after_reset");
    for (int k = 0; k < 4; k++) step_model("shadow_cleared", 1'b0, 1'b1, 300 + k, 50);

    // Randomized scene updates, frame latches and pixels.
    step_model("rand_latch", 1'b1, 1'b0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      int bi;
      if ($urandom_range(0, 7) == 0) begin
        bi = int'($urandom_range(0, NB - 1));
        b_act[bi] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        b_x[bi]   = rand_coord(2047, 35, 11);
        b_y[bi]   = rand_coord(1023, 12, 11);
      end
      step_model("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
                 rand_coord(2047, 40, 12), rand_coord(1023, 15, 13));
    end
    step_model("drain", 1'b0, 1'b0, 0, 0);
    step_model("drain", 1'b0, 1'b0, 0, 0);

    e = ex("done", 0, 0, 1'b0, 0, 0);
    if (e.hit) $display("unreachable");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
